// File: rtl/interval_timer_ctrl_if.sv
// interval_timer_ctrl_if: configuration, control and status signals of the interval timer
interface interval_timer_ctrl_if #(parameter int WIDTH = 8);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] period;
  logic             periodic;
  logic             enable;
  logic             abort;
  logic             done_ack;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             done;
  logic             busy;
  modport slave (input cfg_valid, period, periodic, enable, abort, done_ack,
                 output cfg_ready, count, tick, done, busy);
  modport master (output cfg_valid, period, periodic, enable, abort, done_ack,
                  input cfg_ready, count, tick, done, busy);
endinterface

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: one-shot / auto-reload interval timer with cfg handshake, abort and done ack
module interval_timer_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  interval_timer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, period_q, period_d;
  logic periodic_q, periodic_d, tick_q, tick_d;
  logic terminal;
  assign terminal = bus.enable && (count_q == period_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      period_q <= '0;
      periodic_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      period_q <= period_d;
      periodic_q <= periodic_d;
      tick_q <= tick_d;
    end
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    period_d = period_q;
    periodic_d = periodic_q;
    tick_d = 1'b0;
    case (state_q)
      IDLE: if (bus.cfg_valid) begin
        period_d = bus.period;
        periodic_d = bus.periodic;
        state_d = LOAD;
      end
      LOAD: begin
        count_d = '0;
        state_d = RUN;
      end
      RUN: if (terminal) begin
        tick_d = 1'b1;
        count_d = periodic_q ? '0 : count_q;
        state_d = periodic_q ? RUN : DONE;
      end else if (bus.enable) count_d = count_q + WIDTH'(1);
      DONE: state_d = bus.done_ack ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // abort outranks terminal and done_ack, but never blocks an IDLE handshake
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      count_d = '0;
      tick_d = 1'b0;
    end
  end
  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.busy = (state_q == LOAD) || (state_q == RUN);
  assign bus.count = count_q;
  assign bus.tick = tick_q;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed vectors with a scoreboard queue checked by a separate monitor
module tb_interval_timer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int nstep = 0;
  typedef struct {logic [11:0] v; int id;} exp_t;
  exp_t exp_q[$];
  interval_timer_ctrl_if #(.WIDTH(8)) bus();
  interval_timer_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [11:0] snap();
    return {bus.count, bus.tick, bus.done, bus.busy, bus.cfg_ready};
  endfunction
  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got count=%0d tick=%b done=%b busy=%b rdy=%b, want count=%0d tick=%b done=%b busy=%b rdy=%b",
               name, act[11:4], act[3], act[2], act[1], act[0], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("step%0d", e.id), snap(), e.v);
    end
  end
  task automatic step(input logic cv, input logic [7:0] p, input logic pm, input logic en,
                      input logic ab, input logic ack, input logic [7:0] c,
                      input logic t, input logic d, input logic b, input logic r);
    @(negedge clk);
    bus.cfg_valid = cv;
    bus.period = p;
    bus.periodic = pm;
    bus.enable = en;
    bus.abort = ab;
    bus.done_ack = ack;
    exp_q.push_back('{v: {c, t, d, b, r}, id: nstep});
    nstep++;
  endtask
  initial begin
    bus.cfg_valid = 0; bus.period = 0; bus.periodic = 0;
    bus.enable = 0; bus.abort = 0; bus.done_ack = 0;
    #1 rst = 1'b1;
    #1 chk("reset", snap(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk) rst = 1'b0;
    // one-shot period 3; done_ack while running must be ignored
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 3, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 1);
    // periodic period 2, nine enabled RUN cycles
    step(1, 2, 1, 1, 0, 0, 3, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++)
      step(0, 0, 0, 1, 0, 0, 8'((i + 1) % 3), i % 3 == 2, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    // periodic period 5 with enable toggling
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++)
      step(0, 0, 0, i % 2 == 0, 0, 0, 8'((i / 2 + 1) % 6), i == 10, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    // one-shot period 0
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    // periodic period 255: full range, no wrap before terminal
    step(1, 255, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i < 256; i++)
      step(0, 0, 0, 1, 0, 0, 8'(i), 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    // abort on terminal, then abort with cfg in IDLE
    step(1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 4, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 4, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 4, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
    // asynchronous reset mid-RUN at count 7
    step(1, 20, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i < 8; i++)
      step(0, 0, 0, 1, 0, 0, 8'(i), 0, 0, 1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", snap(), {8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_q.push_back('{v: {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}, id: nstep});
    nstep++;
    @(negedge clk) rst = 1'b0;
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of the period register and the count register.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port cfg_valid, input, 1 bit: a configuration request is presented.
REQ-005 SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-006 SHALL have port period, input, WIDTH bits: terminal count value, sampled on cfg handshake.
REQ-007 SHALL have port periodic, input, 1 bit: 1 = auto-reload mode, 0 = one-shot; sampled on cfg handshake.
REQ-008 SHALL have port enable, input, 1 bit: count enable, acting as carry-in to the counter.
REQ-009 SHALL have port abort, input, 1 bit: synchronous cancel of the active timer.
REQ-010 SHALL have port done_ack, input, 1 bit: clears the one-shot completion flag.
REQ-011 SHALL have port count, output, WIDTH bits: current registered count value.
REQ-012 SHALL have port tick, output, 1 bit: one-cycle registered terminal-count pulse.
REQ-013 SHALL have port done, output, 1 bit: high while in state DONE.
REQ-014 SHALL have port busy, output, 1 bit: high in states LOAD and RUN.

Function
REQ-015 SHALL implement an FSM with four states: IDLE, LOAD, RUN, DONE.
REQ-016 SHALL drive cfg_ready = 1 only in IDLE, decoded from the state register.
REQ-017 SHALL, in IDLE on cfg_valid=1, latch period and periodic into internal registers and go to LOAD on the next edge; cfg_valid outside IDLE is ignored.
REQ-018 SHALL, in LOAD, set count to 0 and go to RUN after exactly one cycle, ignoring enable.
REQ-019 SHALL, in RUN with enable=0, hold count.
REQ-020 SHALL, in RUN with enable=1 and count != period_reg, increment count by 1 (modulo 2^WIDTH, no carry out).
REQ-021 SHALL, in RUN with enable=1 and count == period_reg (terminal), set tick=1 for exactly the following cycle.
REQ-022 SHALL, on a terminal event in periodic mode, set count to 0 and remain in RUN.
REQ-023 SHALL, on a terminal event in one-shot mode, hold count at period_reg and go to DONE.
REQ-024 SHALL produce P+1 enabled RUN cycles per tick for period P; P=0 gives a tick on every enabled RUN cycle, and P=2^WIDTH-1 reaches terminal without wrap.
REQ-025 SHALL, in DONE, hold count and assert done, and go to IDLE on the edge where done_ack=1; done_ack in any other state has no effect.
REQ-026 SHALL, on abort=1 in LOAD, RUN or DONE, go to IDLE, clear count to 0 and suppress any tick for that edge (abort beats terminal); abort in IDLE is ignored and does not block a simultaneous cfg handshake.
REQ-027 SHALL give abort priority over done_ack when both are high in DONE (result: IDLE, count 0).
REQ-028 SHALL keep period_reg and periodic_reg constant from the cfg handshake until the next cfg handshake.

Reset
REQ-029 SHALL, while rst=1 regardless of clk, force state=IDLE, count=0, tick=0, done=0, busy=0, cfg_ready=1, period_reg=0, periodic_reg=0.
REQ-030 SHALL, on rst asserted mid-operation (LOAD/RUN/DONE), abandon the operation with no tick; the first edge after rst release is evaluated from IDLE.

Verification
REQ-031 SHALL be verified by: one-shot period=3, enable=1 continuously -> busy=1 for the LOAD cycle plus 4 RUN cycles, count 0,1,2,3, tick pulse once, done=1 with count=3; done_ack -> IDLE, cfg_ready=1.
REQ-032 SHALL be verified by: periodic period=2, enable=1 for 9 RUN cycles -> tick on cycles following RUN cycles 3, 6 and 9, count sequence 0,1,2,0,1,2,...
REQ-033 SHALL be verified by: periodic period=5 with enable toggling 1,0,1,0,... -> count advances only on enabled cycles; tick after the 6th enabled cycle.
REQ-034 SHALL be verified by: one-shot period=0 -> tick and DONE after the first enabled RUN cycle; periodic period=255 -> count reaches 255 then 0, one tick.
REQ-035 SHALL be verified by: abort asserted in the same cycle as terminal (count==period_reg, enable=1) -> no tick, state IDLE, count=0; then abort together with cfg_valid in IDLE -> configuration accepted.
REQ-036 SHALL be verified by: rst pulsed asynchronously between clk edges during RUN with count=7 -> count=0, busy=0, cfg_ready=1 immediately, with no tick.
